// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its instruction buffer.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   // Clears the byte-offset bits of a PC so that it is instruction aligned.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES) - XLEN'(1));

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } fseq_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Sequential PC increment; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instruction} entries between the sequencer and decode.
// Flush has priority over push and pop; the head is presented straight from storage.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_c;
   logic             do_pop_c;

   // Qualified push/pop and next pointer/occupancy values.
   always_comb begin
      do_push_c = push && (count_q != CNT_W'(DEPTH)) && !flush;
      do_pop_c  = pop && (count_q != '0) && !flush;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      end
   end

   // Pointer/count registers and entry storage; storage is cleared so an empty head reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push_c) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC generator and instruction buffer in front of the instruction fetch unit.
// Issues one fetch at a time over the fetch_enable/fetch_addr level handshake,
// queues returned {pc, instruction} pairs for decode and handles redirects.
// Optional: FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets in a
// sticky fetch_fault and blocks further fetches; without it the target is
// force-aligned and fetch_fault is tied low.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0]  RESET_PC = 32'h0000_0000,
   parameter int unsigned  DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_enable,
   output logic [31:0] fetch_addr,
   input  logic [31:0] instruction,
   input  logic        instr_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fetch_fault
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fseq_state_t  state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         fe_q, fe_d;
   logic [31:0]  fa_q, fa_d;
   logic         discard_q, discard_d;

   logic         push_c;
   logic         pop_c;
   logic         issue_block_c;
   logic [31:0]  redirect_tgt_c;
   fetch_entry_t push_data_c;
   fetch_entry_t head_c;
   logic [CNT_W-1:0] buf_count_c;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q, fault_d;

   // A misaligned redirect target latches a sticky fault; the raw target is still loaded.
   always_comb begin
      fault_d = fault_q;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         fault_d = 1'b1;
      end
   end

   // Sticky fault register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign redirect_tgt_c = redirect_pc;
   assign issue_block_c  = fault_q;
   assign fetch_fault    = fault_q;
`else
   assign redirect_tgt_c = redirect_pc & ALIGN_MASK;
   assign issue_block_c  = 1'b0;
   assign fetch_fault    = 1'b0;
`endif

   // Next-state, handshake and capture logic; a redirect overrides PC and push.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fe_d      = fe_q;
      fa_d      = fa_q;
      discard_d = discard_q;
      push_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (run && (buf_count_c < CNT_W'(DEPTH)) && !redirect_valid && !issue_block_c) begin
               state_d = ISSUE;
               fe_d    = 1'b1;
               fa_d    = pc_q;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (instr_valid) begin
               state_d = RELEASE;
               fe_d    = 1'b0;
               if (discard_q) begin
                  discard_d = 1'b0;
               end else begin
                  push_c = 1'b1;
                  pc_d   = next_pc(pc_q);
               end
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            fe_d    = 1'b0;
         end
      endcase

      // Any fetch still outstanding after this edge returns stale data and must be dropped.
      if (redirect_valid) begin
         pc_d      = redirect_tgt_c;
         push_c    = 1'b0;
         discard_d = (state_q == ISSUE) || ((state_q == WAIT) && !instr_valid);
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         fe_q      <= 1'b0;
         fa_q      <= RESET_PC;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fe_q      <= fe_d;
         fa_q      <= fa_d;
         discard_q <= discard_d;
      end
   end

   assign push_data_c.pc    = pc_q;
   assign push_data_c.instr = instruction;
   assign pop_c             = out_valid && out_ready;

   fetch_buffer #(
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .push_data (push_data_c),
      .pop       (pop_c),
      .flush     (redirect_valid),
      .head      (head_c),
      .count     (buf_count_c)
   );

   assign fetch_enable = fe_q;
   assign fetch_addr   = fa_q;
   assign out_valid    = (buf_count_c != '0);
   assign out_pc       = head_c.pc;
   assign out_instr    = head_c.instr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 2-cycle-latency fetch unit model.
module tb_fetch_sequencer;

   localparam int unsigned LAT = 2;
   localparam logic [31:0] KEY = 32'h5A00_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_enable;
   logic [31:0] fetch_addr;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fetch_fault;
   logic        addr_mode;

   // Second instance exercising PC wrap from the top of the address space.
   logic        fetch_enable2;
   logic [31:0] fetch_addr2;
   logic [31:0] instruction2;
   logic        instr_valid2;
   logic        out_valid2;
   logic [31:0] out_pc2;
   logic [31:0] out_instr2;
   logic        fetch_fault2;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] fa_log[$];
   logic [31:0] pc_log[$];
   logic [31:0] ins_log[$];
   int          rise_cyc[$];
   int          gap_log[$];
   logic [31:0] fa2_log[$];
   logic [31:0] pc2_log[$];
   logic [31:0] ins2_log[$];
   logic        fe_prev  = 1'b0;
   logic        fe2_prev = 1'b0;
   int          low_run  = 0;
   int          cyc      = 0;
   logic [1:0]  lat_q    = '0;
   logic [1:0]  lat2_q   = '0;

   always #5 clk = ~clk;

   fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_enable   (fetch_enable),
      .fetch_addr     (fetch_addr),
      .instruction    (instruction),
      .instr_valid    (instr_valid),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .fetch_fault    (fetch_fault)
   );

   fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut_wrap (
      .clk            (clk),
      .reset          (reset),
      .run            (1'b1),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .fetch_enable   (fetch_enable2),
      .fetch_addr     (fetch_addr2),
      .instruction    (instruction2),
      .instr_valid    (instr_valid2),
      .out_valid      (out_valid2),
      .out_ready      (1'b1),
      .out_pc         (out_pc2),
      .out_instr      (out_instr2),
      .fetch_fault    (fetch_fault2)
   );

   assign instruction  = addr_mode ? (fetch_addr ^ KEY) : 32'h0000_0013;
   assign instruction2 = fetch_addr2 ^ KEY;

   // Fetch unit model: instr_valid rises LAT cycles after fetch_enable, clears once it drops.
   always @(posedge clk) begin
      if (reset || !fetch_enable) begin
         lat_q <= '0;
         instr_valid <= 1'b0;
      end else if (lat_q == 2'(LAT - 1)) begin
         instr_valid <= 1'b1;
      end else begin
         lat_q <= lat_q + 2'd1;
      end
   end

   always @(posedge clk) begin
      if (reset || !fetch_enable2) begin
         lat2_q <= '0;
         instr_valid2 <= 1'b0;
      end else if (lat2_q == 2'(LAT - 1)) begin
         instr_valid2 <= 1'b1;
      end else begin
         lat2_q <= lat2_q + 2'd1;
      end
   end

   // Monitor: log fetch requests (rising fetch_enable) and accepted buffer heads.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (fetch_enable && !fe_prev) begin
         fa_log.push_back(fetch_addr);
         rise_cyc.push_back(cyc);
         gap_log.push_back(low_run);
      end
      low_run = fetch_enable ? 0 : low_run + 1;
      fe_prev = fetch_enable;
      if (!reset && out_valid && out_ready) begin
         pc_log.push_back(out_pc);
         ins_log.push_back(out_instr);
      end
      if (fetch_enable2 && !fe2_prev) fa2_log.push_back(fetch_addr2);
      fe2_prev = fetch_enable2;
      if (!reset && out_valid2) begin
         pc2_log.push_back(out_pc2);
         ins2_log.push_back(out_instr2);
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h exp %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      fa_log.delete(); pc_log.delete(); ins_log.delete();
      rise_cyc.delete(); gap_log.delete();
      fa2_log.delete(); pc2_log.delete(); ins2_log.delete();
      low_run = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick(3);
      clear_logs();
   endtask

   // Wait (bounded) until a fetch to address a is being requested.
   task automatic wait_addr(input logic [31:0] a, input string tag);
      int k = 0;
      while (!(fetch_enable && fetch_addr == a) && k < 80) begin
         tick(1);
         k++;
      end
      chk_eq(tag, 32'(fetch_enable && fetch_addr == a), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!out_valid && k < 80) begin
         tick(1);
         k++;
      end
      chk_eq(tag, 32'(out_valid), 32'd1);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; out_ready = 1'b0; addr_mode = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;

      // Reset values.
      do_reset();
      chk_eq("rst_fe",        32'(fetch_enable), 32'd0);
      chk_eq("rst_addr",      fetch_addr, 32'h0);
      chk_eq("rst_valid",     32'(out_valid), 32'd0);
      chk_eq("rst_out_pc",    out_pc, 32'h0);
      chk_eq("rst_out_instr", out_instr, 32'h0);
      chk_eq("rst_fault",     32'(fetch_fault), 32'd0);
      chk_eq("rst_wrap_addr", fetch_addr2, 32'hFFFF_FFFC);

      // Sequential fetch stream; drop run while the fourth fetch is in flight.
      reset = 1'b0; run = 1'b1; out_ready = 1'b1;
      wait_addr(32'hC, "t1_wait_c");
      tick(1);
      run = 1'b0;
      tick(20);
      chk_eq("t1_nfetch", 32'(fa_log.size()), 32'd4);
      chk_eq("t1_fa0", fa_log[0], 32'h0);
      chk_eq("t1_fa1", fa_log[1], 32'h4);
      chk_eq("t1_fa2", fa_log[2], 32'h8);
      chk_eq("t1_fa3", fa_log[3], 32'hC);
      chk_eq("t1_npop", 32'(pc_log.size()), 32'd4);
      chk_eq("t1_pc0", pc_log[0], 32'h0);
      chk_eq("t1_pc1", pc_log[1], 32'h4);
      chk_eq("t1_pc2", pc_log[2], 32'h8);
      chk_eq("t1_pc3", pc_log[3], 32'hC);
      chk_eq("t1_ins0", ins_log[0], 32'h13);
      chk_eq("t1_ins2", ins_log[2], 32'h13);
      chk_eq("t1_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'd5);
      chk_eq("t1_fe_gap", 32'(gap_log[1] >= 1), 32'd1);
      chk_eq("t1_stop_fe", 32'(fetch_enable), 32'd0);
      chk_eq("wrap_fa0", fa2_log[0], 32'hFFFF_FFFC);
      chk_eq("wrap_fa1", fa2_log[1], 32'h0);
      chk_eq("wrap_pc0", pc2_log[0], 32'hFFFF_FFFC);
      chk_eq("wrap_ins0", ins2_log[0], 32'hA5FF_FFFC);
      chk_eq("wrap_pc1", pc2_log[1], 32'h0);

      // Full buffer stops issue; one pop allows exactly one more fetch.
      do_reset();
      addr_mode = 1'b1;
      reset = 1'b0; run = 1'b1;
      tick(40);
      chk_eq("t2_nfetch", 32'(fa_log.size()), 32'd4);
      chk_eq("t2_fa3", fa_log[3], 32'hC);
      chk_eq("t2_fe_off", 32'(fetch_enable), 32'd0);
      chk_eq("t2_head", out_pc, 32'h0);
      chk_eq("t2_head_ins", out_instr, 32'h5A00_0000);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(20);
      chk_eq("t2_npop", 32'(pc_log.size()), 32'd1);
      chk_eq("t2_nfetch2", 32'(fa_log.size()), 32'd5);
      chk_eq("t2_fa4", fa_log[4], 32'h10);
      chk_eq("t2_head2", out_pc, 32'h4);
      chk_eq("t2_fe_off2", 32'(fetch_enable), 32'd0);

      // Redirect while waiting on 0x8: word dropped, buffer flushed, restart at 0x100.
      do_reset();
      reset = 1'b0; run = 1'b1;
      wait_addr(32'h8, "t3_wait_8");
      tick(1);
      chk_eq("t3_pre_head", out_pc, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick(1);
      redirect_valid = 1'b0;
      chk_eq("t3_flushed", 32'(out_valid), 32'd0);
      chk_eq("t3_inflight", 32'(fetch_enable), 32'd1);
      wait_addr(32'h100, "t3_addr");
      wait_valid("t3_wait_valid");
      chk_eq("t3_out_pc", out_pc, 32'h100);
      chk_eq("t3_out_ins", out_instr, 32'h5A00_0100);

      // Redirect coinciding with capture and a pop.
      do_reset();
      reset = 1'b0; run = 1'b1;
      wait_addr(32'h4, "t4_wait_4");
      tick(2);
      chk_eq("t4_iv", 32'(instr_valid), 32'd1);
      chk_eq("t4_pre_valid", 32'(out_valid), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
      tick(1);
      redirect_valid = 1'b0; out_ready = 1'b0;
      chk_eq("t4_empty", 32'(out_valid), 32'd0);
      chk_eq("t4_fe_drop", 32'(fetch_enable), 32'd0);
      wait_addr(32'h200, "t4_addr");
      wait_valid("t4_wait_valid");
      chk_eq("t4_out_pc", out_pc, 32'h200);

      // Misaligned redirect target.
      do_reset();
      reset = 1'b0;
      tick(2);
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick(1);
      redirect_valid = 1'b0;
      chk_eq("t6_idle_nfetch", 32'(fa_log.size()), 32'd0);
      run = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      tick(30);
      chk_eq("t6_fault", 32'(fetch_fault), 32'd1);
      chk_eq("t6_no_fetch", 32'(fa_log.size()), 32'd0);
      chk_eq("t6_fe_off", 32'(fetch_enable), 32'd0);
`else
      wait_addr(32'h100, "t6_addr");
      chk_eq("t6_no_fault", 32'(fetch_fault), 32'd0);
      wait_valid("t6_wait_valid");
      chk_eq("t6_out_pc", out_pc, 32'h100);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
